// File: rtl/result_bcd_conv.sv
// result_bcd_conv: sequential signed-binary to BCD converter.
// Takes the 16-bit two's-complement calculator result, runs a 16-iteration
// shift-and-add-3 (double-dabble) conversion on a single shared datapath,
// and presents sign, five BCD digits and a leading-zero blank mask.
module result_bcd_conv #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        neg,
  output logic [19:0] digits,
  output logic [4:0]  blank
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Blank value shown after reset: a zero result displays a single "0".
  localparam logic [4:0] BLANK_RESET = BLANK_LEADING ? 5'b11110 : 5'b00000;

  state_t      state_q, state_d;
  logic [15:0] mag_q;        // magnitude being shifted out MSB-first
  logic [19:0] acc_q;        // BCD accumulator
  logic [3:0]  cnt_q;        // iteration counter, 0..15
  logic        neg_r;        // sign captured at acceptance

  logic        accept;
  logic        last_iter;
  logic [15:0] mag_in;
  logic [19:0] acc_adj;
  logic [19:0] acc_next;
  logic [15:0] mag_next;
  logic [4:0]  mask_next;

  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (state_q == SHIFT) && (cnt_q == 4'd15);

  // Magnitude of the incoming value; 0x8000 negates to 32768 as unsigned.
  assign mag_in = value[15] ? (~value + 16'd1) : value;

  // Add 3 to every accumulator nibble that is 5 or more, ahead of the shift.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // One shift of {accumulator, magnitude}: the magnitude MSB enters the BCD LSB.
  assign acc_next = {acc_adj[18:0], mag_q[15]};
  assign mag_next = {mag_q[14:0], 1'b0};

  // Leading-zero mask of the final accumulator: bit i set iff digits i..4 are
  // all zero, for i = 1..4. The units digit is never blanked.
  always_comb begin
    mask_next    = 5'b00000;
    mask_next[4] = (acc_next[19:16] == 4'd0);
    mask_next[3] = mask_next[4] && (acc_next[15:12] == 4'd0);
    mask_next[2] = mask_next[3] && (acc_next[11:8]  == 4'd0);
    mask_next[1] = mask_next[2] && (acc_next[7:4]   == 4'd0);
    if (!BLANK_LEADING)
      mask_next = 5'b00000;
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered busy/done flags derived from the next state.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      // NOTE: state is held with non-blocking assignments so every register in
      // this block samples the pre-edge values, independent of statement order.
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

  // Conversion datapath: load on acceptance, iterate while in SHIFT.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mag_q <= 16'd0;
      acc_q <= 20'd0;
      cnt_q <= 4'd0;
      neg_r <= 1'b0;
    end else if (accept) begin
      mag_q <= mag_in;
      acc_q <= 20'd0;
      cnt_q <= 4'd0;
      neg_r <= value[15];
    end else if (state_q == SHIFT) begin
      mag_q <= mag_next;
      acc_q <= acc_next;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Output registers: loaded on the edge that enters DONE, held otherwise.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      neg    <= 1'b0;
      digits <= 20'd0;
      blank  <= BLANK_RESET;
    end else if (last_iter) begin
      neg    <= neg_r;
      digits <= acc_next;
      blank  <= mask_next;
    end
  end

endmodule

// File: tb/tb_result_bcd_conv.sv
// Testbench for result_bcd_conv: table-driven conversions plus hand-written
// sequences for start-while-busy, back-to-back start and mid-run reset.
module tb_result_bcd_conv;

  logic        clk;
  logic        nRST;
  logic        start;
  logic [15:0] value;

  logic        busy_a, done_a, neg_a;
  logic [19:0] digits_a;
  logic [4:0]  blank_a;

  logic        busy_b, done_b, neg_b;
  logic [19:0] digits_b;
  logic [4:0]  blank_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] value;
    logic [19:0] digits;
    logic        neg;
    logic [4:0]  blank;
  } vec_t;

  vec_t vecs[10];

  result_bcd_conv #(.BLANK_LEADING(1'b1)) dut_a (
    .clk    (clk),
    .nRST   (nRST),
    .start  (start),
    .value  (value),
    .busy   (busy_a),
    .done   (done_a),
    .neg    (neg_a),
    .digits (digits_a),
    .blank  (blank_a)
  );

  result_bcd_conv #(.BLANK_LEADING(1'b0)) dut_b (
    .clk    (clk),
    .nRST   (nRST),
    .start  (start),
    .value  (value),
    .busy   (busy_b),
    .done   (done_b),
    .neg    (neg_b),
    .digits (digits_b),
    .blank  (blank_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge. Pulses start for one edge, optionally re-pulses start
  // with 999 while busy, waits for done and checks latency and outputs. Returns
  // at the negedge of the first IDLE cycle after done.
  task automatic run_conv(input vec_t v, input int inject_at);
    int  lat;
    bit  seen;
    value = v.value;
    start = 1'b1;
    @(posedge clk);            // acceptance edge k
    @(negedge clk);
    start = 1'b0;
    value = 16'hDEAD;          // value only needs to be stable at acceptance
    check("busy_after_accept", {31'd0, busy_a}, 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (lat == inject_at) begin
        start = 1'b1;
        value = 16'd999;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done_a) seen = 1'b1;
      else if (lat < 16) check("busy_during_conv", {31'd0, busy_a}, 32'd1);
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      // done is high in the cycle after edge k+16
      check("latency_edges", lat, 32'd16);
      check("busy_in_done", {31'd0, busy_a}, 32'd1);
      check("digits", {12'd0, digits_a}, {12'd0, v.digits});
      check("neg", {31'd0, neg_a}, {31'd0, v.neg});
      check("blank", {27'd0, blank_a}, {27'd0, v.blank});
      check("done_b", {31'd0, done_b}, 32'd1);
      check("digits_b", {12'd0, digits_b}, {12'd0, v.digits});
      check("blank_b_zero", {27'd0, blank_b}, 32'd0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done_a}, 32'd0);
      check("busy_idle", {31'd0, busy_a}, 32'd0);
      check("digits_hold", {12'd0, digits_a}, {12'd0, v.digits});
    end
  endtask

  initial begin
    vec_t v;
    int   edges;
    bit   stray_done;

    vecs[0] = '{16'd12345, 20'h12345, 1'b0, 5'b00000};
    vecs[1] = '{16'hFFF9,  20'h00007, 1'b1, 5'b11110};
    vecs[2] = '{16'h8000,  20'h32768, 1'b1, 5'b00000};
    vecs[3] = '{16'h7FFF,  20'h32767, 1'b0, 5'b00000};
    vecs[4] = '{16'hFFFF,  20'h00001, 1'b1, 5'b11110};
    vecs[5] = '{16'd0,     20'h00000, 1'b0, 5'b11110};
    vecs[6] = '{16'd1000,  20'h01000, 1'b0, 5'b10000};
    vecs[7] = '{16'hFB2E,  20'h01234, 1'b1, 5'b10000};
    vecs[8] = '{16'hFF9C,  20'h00100, 1'b1, 5'b11000};
    vecs[9] = '{16'd9,     20'h00009, 1'b0, 5'b11110};

    nRST  = 1'b0;
    start = 1'b0;
    value = 16'd0;
    repeat (2) @(negedge clk);

    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_neg", {31'd0, neg_a}, 32'd0);
    check("rst_digits", {12'd0, digits_a}, 32'd0);
    check("rst_blank", {27'd0, blank_a}, 32'h1E);
    check("rst_blank_b", {27'd0, blank_b}, 32'd0);

    nRST = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_conv(vecs[i], -1);

    // start re-pulsed with 999 while converting 500: ignored, single done
    v = '{16'd500, 20'h00500, 1'b0, 5'b11000};
    run_conv(v, 3);
    // start in the first IDLE cycle after done is accepted
    v = '{16'd999, 20'h00999, 1'b0, 5'b11000};
    run_conv(v, -1);

    // Reset during SHIFT iteration 8 aborts the conversion immediately
    value = 16'd4321;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    nRST = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_done", {31'd0, done_a}, 32'd0);
    check("midrst_digits", {12'd0, digits_a}, 32'd0);
    check("midrst_blank", {27'd0, blank_a}, 32'h1E);
    stray_done = 1'b0;
    edges = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a || busy_a) stray_done = 1'b1;
      edges++;
    end
    nRST = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done_a || busy_a) stray_done = 1'b1;
      edges++;
    end
    check("midrst_no_done", {31'd0, stray_done}, 32'd0);

    v = '{16'd42, 20'h00042, 1'b0, 5'b11100};
    run_conv(v, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_bcd_conv.md
# result_bcd_conv

Sequential signed-binary to BCD converter downstream of the calculator controller. It takes the 16-bit two's-complement result and its completion pulse, runs a 16-iteration double-dabble conversion, and presents a sign flag, five BCD digits and a leading-zero blank mask to the seven-segment display driver. The shift-and-add-3 datapath is shared across all iterations, so the block has no combinational divider.

## Interface
- BLANK_LEADING, default 1: when 1, `blank` marks leading-zero digits; when 0, `blank` is held at 0.
- clk  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- start  in  1  request conversion of `value`; connects to the controller's `complete`.
- value  in  16  two's-complement result; connects to the controller's `display_output`.
- busy  out  1  conversion in progress; `start` is ignored while high.
- done  out  1  one-cycle pulse; `neg`, `digits` and `blank` are updated and valid.
- neg  out  1  result is negative.
- digits  out  20  five BCD digits; [19:16] is ten-thousands, [3:0] is units.
- blank  out  5  per-digit blank mask; bit i corresponds to digits[4i+3:4i].

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at a rising edge:
  - Capture `value`.
  - Set `neg_r` = value[15].
  - Set `mag` = value[15] ? (~value + 1) : value, as 16-bit unsigned. 0x8000 yields 32768 correctly.
  - Clear the 20-bit BCD accumulator and the iteration counter; go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every accumulator nibble that is ≥5.
  - Shift {accumulator, mag} left by one.
  - Increment the counter.
  - After the 16th iteration (counter = 15 at the edge), go to DONE.
- DONE, one cycle:
  - `done` = 1.
  - Output registers were loaded on the edge entering DONE: `digits` ← accumulator, `neg` ← neg_r, `blank` ← mask.
  - Next state is IDLE unconditionally.
- Blank mask (BLANK_LEADING=1): bit i = 1 iff digits i through 4 are all zero, for i = 1..4. Bit 0 is always 0, so a zero result shows a single "0".
- Outputs hold their last values until the next DONE.
- `start` in SHIFT or DONE is dropped, not queued. A level-high `start` in IDLE starts a new conversion on each pass through IDLE.
- Magnitude never exceeds 32768, so the top digit is always ≤3 and there is no overflow case.

## Timing
- Reset, asynchronous and taking effect immediately:
  - state = IDLE, busy = 0, done = 0, neg = 0, digits = 0.
  - blank = 5'b11110 if BLANK_LEADING, else 0.
  - Internal accumulator and counter are cleared.
- Reset mid-conversion aborts it; no `done` is produced. The first start after reset is released is accepted normally.
- Latency: start sampled at edge k.
  - busy = 1 from after edge k through the DONE cycle.
  - done = 1 for exactly the cycle after edge k+16, i.e. 17 cycles after acceptance.
- Throughput: a new start is accepted at the edge ending DONE+1 (IDLE). The minimum start-to-start interval is 18 cycles.
- `busy` = (state ≠ IDLE), registered. `done` = (state == DONE), registered.
- `value` only needs to be stable at the accepting edge.

## Test plan
- value = 16'd12345, pulse start -> done exactly 17 cycles later; digits = 20'h12345, neg = 0, blank = 5'b00000.
- value = 16'hFFF9 (-7) -> digits = 20'h00007, neg = 1, blank = 5'b11110.
- Extremes:
  - value = 16'h8000 -> digits = 20'h32768, neg = 1.
  - value = 16'h7FFF -> digits = 20'h32767, neg = 0.
  - value = 16'hFFFF -> digits = 20'h00001, neg = 1.
- value = 0 -> digits = 0, neg = 0, blank = 5'b11110. With BLANK_LEADING=0, blank = 0 throughout.
- Start re-pulsed with value = 999 while busy during a 500 conversion -> a single done with digits = 20'h00500. Start in the first IDLE cycle after done with value = 999 -> accepted; digits = 20'h00999.
- nRST low during SHIFT iteration 8 -> busy, done and digits clear immediately with no done pulse. After release, value = 16'd42 -> digits = 20'h00042 after 17 cycles.
